// File: rtl/iob_pkg.sv
// Shared types and constants for the PDS bus responder.
// Holds the FSM state type, the register map indices and the synchronizer depth.
package iob_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DSWAIT,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_SCR  = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_ID   = 2'd3;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/iob_slave_sync2.sv
// Multi-flop synchronizer for one asynchronous PDS strobe.
// Resets to RST_VAL so the strobe reads as negated until real samples arrive.
module sync2
    import iob_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {SYNC_DEPTH{RST_VAL}};
        end else begin
            ff <= {ff[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/iob_slave.sv
// PDS bus responder: decodes 68000-style cycles aimed at an 8-byte register
// window, inserts wait states and answers with DTACK and read data.
module iob_slave
    import iob_pkg::*;
#(
    parameter logic [23:0] BASE  = 24'hF0_0000,
    parameter int unsigned WAITS = 2,
    parameter logic [15:0] ID    = 16'h5753
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        nAS,
    input  logic        RnW,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic [23:1] A,
    input  logic [15:0] Din,
    input  logic [15:0] STAT,
    output logic        DTACK,
    output logic        DOE,
    output logic [15:0] Dout,
    output logic [15:0] CTRL,
    output logic        WSTB
);

    localparam logic [3:0] WAIT_INIT = 4'(WAITS);

    logic       nas_q, nuds_q, nlds_q;
    logic       as_s, uds_s, lds_s;
    logic       as_d;
    state_t     state;
    logic [1:0] reg_idx;
    logic       rnw_l, hit, uds_l, lds_l;
    logic [3:0] count;
    logic [15:0] scratch;
    logic [15:0] rd_data;

    sync2 #(.RST_VAL(1'b1)) u_sync_as  (.clk(CLK), .rst(RES), .d(nAS),  .q(nas_q));
    sync2 #(.RST_VAL(1'b1)) u_sync_uds (.clk(CLK), .rst(RES), .d(nUDS), .q(nuds_q));
    sync2 #(.RST_VAL(1'b1)) u_sync_lds (.clk(CLK), .rst(RES), .d(nLDS), .q(nlds_q));

    assign as_s  = ~nas_q;
    assign uds_s = ~nuds_q;
    assign lds_s = ~nlds_q;

    always_comb begin
        rd_data = 16'h0000;
        case (reg_idx)
            REG_CTRL: rd_data = CTRL;
            REG_SCR:  rd_data = scratch;
            REG_STAT: rd_data = STAT;
            REG_ID:   rd_data = ID;
            default:  rd_data = 16'h0000;
        endcase
    end

    // DTACK, DOE, Dout and the write commit are registered on the WAIT->ACK
    // edge, so they are visible for the whole ACK cycle.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state   <= S_IDLE;
            as_d    <= 1'b0;
            reg_idx <= 2'd0;
            rnw_l   <= 1'b1;
            hit     <= 1'b0;
            uds_l   <= 1'b0;
            lds_l   <= 1'b0;
            count   <= 4'd0;
            scratch <= 16'h0000;
            CTRL    <= 16'h0000;
            DTACK   <= 1'b0;
            DOE     <= 1'b0;
            Dout    <= 16'h0000;
            WSTB    <= 1'b0;
        end else begin
            as_d <= as_s;
            WSTB <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (as_s && !as_d) begin
                        reg_idx <= A[2:1];
                        rnw_l   <= RnW;
                        hit     <= (A[23:3] == BASE[23:3]);
                        state   <= S_DSWAIT;
                    end
                end
                S_DSWAIT: begin
                    if (!as_s) begin
                        state <= S_IDLE;
                    end else if (!hit) begin
                        state <= S_HOLD;
                    end else if (uds_s || lds_s) begin
                        uds_l <= uds_s;
                        lds_l <= lds_s;
                        count <= WAIT_INIT;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!as_s) begin
                        state <= S_IDLE;
                    end else if (count == 4'd0) begin
                        state <= S_ACK;
                        DTACK <= 1'b1;
                        if (rnw_l) begin
                            DOE  <= 1'b1;
                            Dout <= rd_data;
                        end else if (reg_idx == REG_CTRL) begin
                            if (uds_l) CTRL[15:8] <= Din[15:8];
                            if (lds_l) CTRL[7:0]  <= Din[7:0];
                        end else if (reg_idx == REG_SCR) begin
                            if (uds_l) scratch[15:8] <= Din[15:8];
                            if (lds_l) scratch[7:0]  <= Din[7:0];
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_ACK: begin
                    WSTB  <= !rnw_l && (reg_idx == REG_CTRL);
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!as_s) begin
                        DTACK <= 1'b0;
                        DOE   <= 1'b0;
                        Dout  <= 16'h0000;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_slave.sv
// Self-checking bench for iob_slave: directed bus cycles plus randomized ones,
// compared against a register-array model of the responder's behaviour.
module tb_iob_slave;

    localparam logic [23:0] BASE  = 24'hF0_0000;
    localparam int          WAITS = 2;
    localparam logic [15:0] ID    = 16'h5753;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        nAS = 1'b1, RnW = 1'b1, nUDS = 1'b1, nLDS = 1'b1;
    logic [23:1] A = '0;
    logic [15:0] Din = '0, STAT = '0;
    logic        DTACK, DOE, WSTB;
    logic [15:0] Dout, CTRL;

    iob_slave #(.BASE(BASE), .WAITS(WAITS), .ID(ID)) dut (
        .CLK(CLK), .RES(RES), .nAS(nAS), .RnW(RnW), .nUDS(nUDS), .nLDS(nLDS),
        .A(A), .Din(Din), .STAT(STAT), .DTACK(DTACK), .DOE(DOE), .Dout(Dout),
        .CTRL(CTRL), .WSTB(WSTB)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    int wstb_cnt = 0;
    always @(posedge CLK) cyc++;
    always @(negedge CLK) if (WSTB === 1'b1) wstb_cnt++;

    int tests = 0;
    int fails = 0;

    // reference model: writable registers 0/1, STAT live, ID constant
    logic [15:0] mreg [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input int idx);
        case (idx)
            0: return mreg[0];
            1: return mreg[1];
            2: return STAT;
            default: return ID;
        endcase
    endfunction

    task automatic bus_cycle(input string tag, input logic [23:0] addr, input bit rnw,
                             input bit uds, input bit lds, input logic [15:0] din,
                             input int dd, input int abort_at, input bit reset_in_hold);
        bit          hit;
        int          idx, ds_lat, exp_lat, c0, w0, lat, r0, rel;
        bit          aborted, acked;
        logic [15:0] obs_dout, exp_dout, mask;
        logic        obs_doe;
        hit      = (addr[23:3] == BASE[23:3]);
        idx      = int'(addr[2:1]);
        ds_lat   = (dd + 3 > 4) ? dd + 3 : 4;
        exp_lat  = ds_lat + WAITS + 1;
        aborted  = (abort_at >= 0) && (abort_at + 3 <= exp_lat);
        acked    = hit && !aborted;
        exp_dout = model_read(idx);
        lat      = -1;
        obs_dout = 16'h0;
        obs_doe  = 1'b0;

        @(negedge CLK);
        A   = addr[23:1];
        RnW = rnw;
        Din = din;
        nAS = 1'b0;
        if (dd == 0) begin
            nUDS = !uds;
            nLDS = !lds;
        end
        c0 = cyc;
        w0 = wstb_cnt;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (DTACK === 1'b1 && lat < 0) begin
                lat      = cyc - c0;
                obs_dout = Dout;
                obs_doe  = DOE;
            end
            if (i == dd) begin
                nUDS = !uds;
                nLDS = !lds;
            end
            if (i == abort_at) begin
                nAS  = 1'b1;
                nUDS = 1'b1;
                nLDS = 1'b1;
            end
        end

        check({tag, " latency"}, 32'(lat), acked ? 32'(exp_lat) : 32'hFFFF_FFFF);
        if (acked) begin
            check({tag, " doe"}, {31'd0, obs_doe}, {31'd0, rnw});
            check({tag, " dout"}, {16'd0, obs_dout}, rnw ? {16'd0, exp_dout} : 32'd0);
            check({tag, " dtack held"}, {31'd0, DTACK}, 32'd1);
            if (!rnw && idx < 2) begin
                mask = {{8{uds}}, {8{lds}}};
                mreg[idx] = (mreg[idx] & ~mask) | (din & mask);
            end
        end
        check({tag, " wstb"}, 32'(wstb_cnt - w0), (acked && !rnw && idx == 0) ? 32'd1 : 32'd0);

        if (reset_in_hold) begin
            #2 RES = 1'b1;
            #1;
            check({tag, " rst dtack"}, {31'd0, DTACK}, 32'd0);
            check({tag, " rst doe"}, {31'd0, DOE}, 32'd0);
            check({tag, " rst ctrl"}, {16'd0, CTRL}, 32'd0);
            nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
            mreg[0] = 16'h0;
            mreg[1] = 16'h0;
            @(negedge CLK);
            RES = 1'b0;
        end else begin
            @(negedge CLK);
            nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
            r0  = cyc;
            rel = -1;
            for (int i = 1; i <= 10; i++) begin
                @(negedge CLK);
                if (DTACK === 1'b0 && rel < 0) begin
                    rel = cyc - r0;
                    if (acked) begin
                        check({tag, " release doe"}, {31'd0, DOE}, 32'd0);
                        check({tag, " release dout"}, {16'd0, Dout}, 32'd0);
                    end
                end
            end
            check({tag, " release"}, 32'(rel), acked ? 32'd3 : 32'd1);
        end
        check({tag, " ctrl"}, {16'd0, CTRL}, {16'd0, mreg[0]});
    endtask

    initial begin
        logic [23:0] addr;
        mreg[0] = 16'h0;
        mreg[1] = 16'h0;
        #1;
        check("reset dtack", {31'd0, DTACK}, 32'd0);
        check("reset doe",   {31'd0, DOE},   32'd0);
        check("reset dout",  {16'd0, Dout},  32'd0);
        check("reset ctrl",  {16'd0, CTRL},  32'd0);
        check("reset wstb",  {31'd0, WSTB},  32'd0);
        repeat (3) @(negedge CLK);
        RES = 1'b0;
        repeat (2) @(negedge CLK);

        bus_cycle("read id",      BASE + 24'd6, 1'b1, 1'b1, 1'b1, 16'h0,    0, -1, 1'b0);
        bus_cycle("write ctrl",   BASE + 24'd0, 1'b0, 1'b1, 1'b1, 16'h1234, 0, -1, 1'b0);
        bus_cycle("byte ctrl",    BASE + 24'd0, 1'b0, 1'b1, 1'b0, 16'hAB00, 0, -1, 1'b0);
        bus_cycle("read ctrl",    BASE + 24'd0, 1'b1, 1'b1, 1'b1, 16'h0,    0, -1, 1'b0);
        bus_cycle("late ds",      BASE + 24'd2, 1'b0, 1'b1, 1'b1, 16'h5A5A, 4, -1, 1'b0);
        bus_cycle("miss read",    BASE + 24'd8, 1'b1, 1'b1, 1'b1, 16'h0,    0, -1, 1'b0);
        bus_cycle("miss write",   BASE + 24'd8, 1'b0, 1'b1, 1'b1, 16'hFFFF, 0, -1, 1'b0);
        bus_cycle("abort scr",    BASE + 24'd2, 1'b0, 1'b1, 1'b1, 16'hDEAD, 0,  3, 1'b0);
        bus_cycle("read scr",     BASE + 24'd2, 1'b1, 1'b1, 1'b1, 16'h0,    0, -1, 1'b0);
        STAT = 16'hC3A5;
        bus_cycle("read stat",    BASE + 24'd4, 1'b1, 1'b0, 1'b1, 16'h0,    0, -1, 1'b0);
        bus_cycle("write stat",   BASE + 24'd4, 1'b0, 1'b1, 1'b1, 16'hFFFF, 0, -1, 1'b0);
        bus_cycle("rst in hold",  BASE + 24'd0, 1'b0, 1'b1, 1'b1, 16'h7777, 0, -1, 1'b1);
        repeat (2) @(negedge CLK);
        bus_cycle("scr after rst", BASE + 24'd2, 1'b1, 1'b1, 1'b1, 16'h0,   0, -1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int  kind, dd;
            bit  u, l;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) addr = 24'($urandom) & 24'hFF_FFFE;
            else           addr = BASE + 24'(2 * $urandom_range(0, 3));
            u = 1'($urandom);
            l = 1'($urandom);
            if (!u && !l) l = 1'b1;
            dd   = int'($urandom_range(0, 5));
            STAT = 16'($urandom);
            bus_cycle("random", addr, 1'($urandom), u, l, 16'($urandom), dd, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
